// File: rtl/key_debounce_multi.sv
// key_debounce_multi: N independent key channels, each with a 2-flop
// synchroniser, a consecutive-sample debouncer, press/release edge pulses
// and a single long-press pulse. Channels share nothing but the clock/reset.
module key_debounce_multi #(
  parameter int N_KEYS      = 4,
  parameter int SAMPLE_TIME = 4,
  parameter int LONG_TIME   = 20,
  parameter int CNT_W       = 22,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  // Raw pin level that means "not pressed"; the synchroniser resets to it so
  // an idle key never looks like a fresh edge when reset is released.
  localparam logic [N_KEYS-1:0] RELEASED_PIN = (ACTIVE_LOW != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

  // Debounce counter value on which the differing level is accepted.
  localparam logic [CNT_W-1:0] DCNT_LAST = CNT_W'(SAMPLE_TIME - 1);

  // Long-press counter saturation value and the value one step before it.
  localparam logic [CNT_W-1:0] LCNT_MAX  = CNT_W'(LONG_TIME);
  localparam logic [CNT_W-1:0] LCNT_LAST = CNT_W'(LONG_TIME - 1);

  logic [N_KEYS-1:0] meta;
  logic [N_KEYS-1:0] sync_raw;
  logic [N_KEYS-1:0] sync;

  // Two-stage synchroniser for every asynchronous pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta     <= RELEASED_PIN;
      sync_raw <= RELEASED_PIN;
    end else begin
      meta     <= key_in;
      sync_raw <= meta;
    end
  end

  // Normalise so that 1 always means pressed from here on.
  assign sync = (ACTIVE_LOW != 0) ? ~sync_raw : sync_raw;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    logic [CNT_W-1:0] dcnt;
    logic [CNT_W-1:0] lcnt;
    logic             state;
    logic             press;
    logic             rel;
    logic             long_pulse;
    logic             differ;
    logic             accept;

    // A sample disagreeing with the accepted level counts toward a change;
    // the change is taken on the SAMPLE_TIME-th consecutive disagreement.
    assign differ = (sync[i] != state);
    assign accept = differ && (dcnt == DCNT_LAST);

    // Debounce counter and accepted level; any agreeing sample restarts the count.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dcnt  <= '0;
        state <= 1'b0;
      end else if (!differ) begin
        dcnt  <= '0;
      end else if (accept) begin
        dcnt  <= '0;
        state <= ~state;
      end else begin
        dcnt  <= dcnt + CNT_W'(1);
      end
    end

    // Edge pulses registered on the same edge the accepted level changes.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        press <= 1'b0;
        rel   <= 1'b0;
      end else begin
        press <= accept && !state;
        rel   <= accept && state;
      end
    end

    // Long-press timer counts accepted-pressed cycles and saturates so the
    // long pulse fires exactly once per press.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lcnt       <= '0;
        long_pulse <= 1'b0;
      end else if (!state) begin
        lcnt       <= '0;
        long_pulse <= 1'b0;
      end else begin
        if (lcnt != LCNT_MAX) begin
          lcnt <= lcnt + CNT_W'(1);
        end
        long_pulse <= (lcnt == LCNT_LAST);
      end
    end

    assign key_state[i]   = state;
    assign key_press[i]   = press;
    assign key_release[i] = rel;
    assign key_long[i]    = long_pulse;
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi with default parameters
// (4 keys, SAMPLE_TIME=4, LONG_TIME=20, active-low pins).
module tb_key_debounce_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_in;
  logic [3:0] key_state;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_long;

  typedef struct {
    logic [3:0] key_in;
    logic [3:0] st;
    logic [3:0] pr;
    logic [3:0] rl;
    logic [3:0] lg;
  } vec_t;

  vec_t vecs[$];
  int   assert_count = 0;
  int   fail_count   = 0;

  // 10-unit free-running clock.
  always #5 clk = ~clk;

  key_debounce_multi #(
    .N_KEYS(4), .SAMPLE_TIME(4), .LONG_TIME(20), .CNT_W(22), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_in(key_in),
    .key_state(key_state),
    .key_press(key_press),
    .key_release(key_release),
    .key_long(key_long)
  );

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic void add_rep(input int n, input logic [3:0] kin, input logic [3:0] st,
                                  input logic [3:0] pr, input logic [3:0] rl, input logic [3:0] lg);
    vec_t v;
    v.key_in = kin;
    v.st = st;
    v.pr = pr;
    v.rl = rl;
    v.lg = lg;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input vec_t v, input int idx);
    key_in = v.key_in;
    step();
    checkOutput($sformatf("vec%0d state", idx), key_state, v.st);
    checkOutput($sformatf("vec%0d press", idx), key_press, v.pr);
    checkOutput($sformatf("vec%0d release", idx), key_release, v.rl);
    checkOutput($sformatf("vec%0d long", idx), key_long, v.lg);
  endtask

  // 50-edge press on one channel: pin low for edges 1..40 (optionally high
  // for edges 16..18), expecting press@6, long@26, release@46.
  task automatic run_long(input int ch, input bit glitch);
    logic [3:0] pin, e_st, e_pr, e_rl, e_lg;
    for (int t = 1; t <= 50; t++) begin
      pin = 4'hF;
      if (t <= 40 && !(glitch && t >= 16 && t <= 18)) pin[ch] = 1'b0;
      key_in = pin;
      step();
      e_st = '0; e_pr = '0; e_rl = '0; e_lg = '0;
      e_st[ch] = (t >= 6 && t <= 45);
      e_pr[ch] = (t == 6);
      e_lg[ch] = (t == 26);
      e_rl[ch] = (t == 46);
      checkOutput($sformatf("long ch%0d g%0d t%0d state", ch, glitch, t), key_state, e_st);
      checkOutput($sformatf("long ch%0d g%0d t%0d press", ch, glitch, t), key_press, e_pr);
      checkOutput($sformatf("long ch%0d g%0d t%0d long", ch, glitch, t), key_long, e_lg);
      checkOutput($sformatf("long ch%0d g%0d t%0d release", ch, glitch, t), key_release, e_rl);
    end
  endtask

  initial begin
    logic b;
    logic [3:0] e;

    // Single press/release on channel 0.
    add_rep(5, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0);
    add_rep(1, 4'hE, 4'h1, 4'h1, 4'h0, 4'h0);
    add_rep(2, 4'hE, 4'h1, 4'h0, 4'h0, 4'h0);
    add_rep(5, 4'hF, 4'h1, 4'h0, 4'h0, 4'h0);
    add_rep(1, 4'hF, 4'h0, 4'h0, 4'h1, 4'h0);
    add_rep(2, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
    // Simultaneous press on channels 1 and 3.
    add_rep(5, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0);
    add_rep(1, 4'h5, 4'hA, 4'hA, 4'h0, 4'h0);
    add_rep(2, 4'h5, 4'hA, 4'h0, 4'h0, 4'h0);
    add_rep(5, 4'hF, 4'hA, 4'h0, 4'h0, 4'h0);
    add_rep(1, 4'hF, 4'h0, 4'h0, 4'hA, 4'h0);
    add_rep(2, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
    // Channel 0 bouncing every 2 cycles never qualifies.
    for (int k = 0; k < 20; k++) begin
      b = ((k / 2) % 2) == 1;
      add_rep(1, {3'b111, b}, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    add_rep(6, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);

    // Reset state.
    rst = 1'b1;
    key_in = 4'hF;
    step();
    step();
    checkOutput("reset state", key_state, 4'h0);
    checkOutput("reset press", key_press, 4'h0);
    checkOutput("reset release", key_release, 4'h0);
    checkOutput("reset long", key_long, 4'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    run_long(2, 1'b0);
    run_long(0, 1'b1);

    // Asynchronous reset mid-press, then re-qualification of the held key.
    key_in = 4'hE;
    for (int t = 1; t <= 10; t++) step();
    checkOutput("pre-reset state", key_state, 4'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset state", key_state, 4'h0);
    checkOutput("async reset press", key_press, 4'h0);
    checkOutput("async reset release", key_release, 4'h0);
    checkOutput("async reset long", key_long, 4'h0);
    #2 rst = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      step();
      e = (t >= 6) ? 4'h1 : 4'h0;
      checkOutput($sformatf("rereq t%0d state", t), key_state, e);
      e = (t == 6) ? 4'h1 : 4'h0;
      checkOutput($sformatf("rereq t%0d press", t), key_press, e);
      checkOutput($sformatf("rereq t%0d release", t), key_release, 4'h0);
    end
    key_in = 4'hF;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
